// File: rtl/cla32_addsub_pipe.sv
// rtl/cla32_addsub_pipe.sv - two-stage pipelined 32-bit CLA adder/subtractor
// Low 16-bit slice and inter-slice carry in stage 1; high slice and flags in stage 2.
module cla32_addsub_pipe #(
  parameter int SLICE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*SLICE-1:0] a,
  input  logic [2*SLICE-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*SLICE-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               zero
);

  localparam int W = 2 * SLICE;

  // Carries into each bit of a 4-wide lookahead group, fully expanded.
  function automatic logic [3:0] la4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    logic       t;
    for (int i = 0; i < 4; i++) begin
      c[i] = ci;
      for (int k = 0; k < i; k++) c[i] = c[i] & p[k];
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        c[i] = c[i] | t;
      end
    end
    return c;
  endfunction

  function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Returns {block G, block P, sum}; the slice is four 4-bit groups under a second lookahead level.
  function automatic logic [SLICE+1:0] cla16(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y,
                                             input logic ci);
    logic [SLICE-1:0] g, p, s;
    logic [3:0]       gg, pp, gc, bc;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = grp_g(g[4*k +: 4], p[4*k +: 4]);
      pp[k] = &p[4*k +: 4];
    end
    gc = la4(gg, pp, ci);
    for (int k = 0; k < 4; k++) begin
      bc = la4(g[4*k +: 4], p[4*k +: 4], gc[k]);
      s[4*k +: 4] = p[4*k +: 4] ^ bc;
    end
    return {grp_g(gg, pp), &pp, s};
  endfunction

  logic [W-1:0]     beff;
  logic [SLICE+1:0] lo, hi;
  logic             c16_next, cout_next;
  logic [W-1:0]     sum_next;

  logic             s1_valid, s1_c16;
  logic [SLICE-1:0] s1_sum_lo, s1_a_hi, s1_b_hi;
  logic             s2_valid;
  logic             adv2, load1;

  assign beff      = b ^ {W{sub}};
  assign lo        = cla16(a[SLICE-1:0], beff[SLICE-1:0], sub);
  assign c16_next  = lo[SLICE+1] | (lo[SLICE] & sub);

  assign hi        = cla16(s1_a_hi, s1_b_hi, s1_c16);
  assign cout_next = hi[SLICE+1] | (hi[SLICE] & s1_c16);
  assign sum_next  = {hi[SLICE-1:0], s1_sum_lo};

  assign adv2      = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | adv2;
  assign load1     = in_valid & in_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_c16    <= 1'b0;
      s1_sum_lo <= '0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s2_valid  <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (adv2) begin
        s2_valid <= 1'b1;
        sum      <= sum_next;
        cout     <= cout_next;
        // Overflow is judged on the conditioned operand, so one rule covers add and sub.
        ovf      <= (s1_a_hi[SLICE-1] == s1_b_hi[SLICE-1]) & (sum_next[W-1] != s1_a_hi[SLICE-1]);
        zero     <= ~|sum_next;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end

      if (load1) begin
        s1_valid  <= 1'b1;
        s1_sum_lo <= lo[SLICE-1:0];
        s1_c16    <= c16_next;
        s1_a_hi   <= a[W-1:SLICE];
        s1_b_hi   <= beff[W-1:SLICE];
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla32_addsub_pipe.sv
// tb/tb_cla32_addsub_pipe.sv - randomized and directed bench for cla32_addsub_pipe
// Results are predicted with plain integer arithmetic and matched in acceptance order.
module tb_cla32_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout, ovf, zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [34:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [34:0] hold_val;
  logic        obs_ir, obs_ov;

  cla32_addsub_pipe #(.SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {sum, cout, ovf, zero} from the arithmetic definition of the operation.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] r;
    logic        c, v;
    longint      sx, sy, sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r  = x - y;
      c  = (x >= y);
      sr = sx - sy;
    end else begin
      r  = x + y;
      c  = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
      sr = sx + sy;
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {r, c, v, (r == 32'd0)};
  endfunction

  // One clock cycle: drive at negedge, then account for the handshakes the next posedge will take.
  task automatic step(input logic iv, input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                      input logic ordy);
    logic [34:0] e;
    @(negedge clk);
    in_valid  = iv;
    a         = ta;
    b         = tb_;
    sub       = ts;
    out_ready = ordy;
    #1;
    obs_ir = in_ready;
    obs_ov = out_valid;
    if (hold_pending)
      check("hold_stable", {29'd0, sum, cout, ovf, zero}, {29'd0, hold_val});
    hold_pending = out_valid && !out_ready;
    hold_val     = {sum, cout, ovf, zero};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {29'd0, sum, cout, ovf, zero}, {29'd0, e});
      end
    end
    if (iv && in_ready) exp_q.push_back(model(ta, tb_, ts));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_sum"}, {32'd0, sum}, 64'd0);
    check({tag, "_flags"}, {61'd0, cout, ovf, zero}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("reset");

    // Inter-slice carry and exact latency.
    step(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    check("lat_accept", {63'd0, obs_ir}, 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("lat_cycle1_ov", {63'd0, obs_ov}, 64'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("lat_cycle2_ov", {63'd0, obs_ov}, 64'd1);
    idle(2);

    // Directed corners: overflow, wrap to zero, borrow, equal-operand subtract.
    step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    step(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
    idle(3);
    check("directed_drained", exp_q.size(), 64'd0);

    // Eight back-to-back beats, alternating add/sub.
    for (int i = 0; i < 10; i++) begin
      step(i < 8, $urandom, $urandom, i[0], 1'b1);
      if (i < 8) check("stream_in_ready", {63'd0, obs_ir}, 64'd1);
      if (i >= 2) check("stream_out_valid", {63'd0, obs_ov}, 64'd1);
    end
    idle(2);

    // Backpressure: two beats fit, then in_ready drops.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, $urandom, $urandom_range(0, 1), 1'b0);
      check("bp_in_ready", {63'd0, obs_ir}, (i < 2) ? 64'd1 : 64'd0);
    end
    check("bp_accepted", exp_q.size(), 64'd2);
    idle(4);
    check("bp_drained", exp_q.size(), 64'd0);

    // Reset with both stages full; the discarded beats must never appear.
    step(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE_F00D, 32'h2222_2222, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle(3);

    // Random traffic with random backpressure and interleaved add/sub.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_operand(), rand_operand(), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0);
    idle(4);
    check("final_drained", exp_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cla32_addsub_pipe.md
Name: cla32_addsub_pipe

Overview:
- Two-stage pipelined 32-bit adder/subtractor built from two 16-bit carry-lookahead slices; subtraction is performed as A + ~B + 1.
- Stage 1 resolves the low 16-bit slice and registers the inter-slice carry c16.
- Stage 2 resolves the high slice using the registered carry and produces sum and flags.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides. Sustains one operation per cycle.

Parameters:
- SLICE, 16, width of each CLA slice. Total width is 2*SLICE. Only 16 is required to be supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept an operand beat this cycle
- a  in  32  operand A
- b  in  32  operand B
- sub  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result this cycle
- sum  out  32  result, modulo 2^32
- cout  out  1  carry out of bit 31 (for subtraction: 1 = no borrow, i.e. A ≥ B unsigned)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: rst_n sampled low at a clk edge does the following:
  - Clears s1_valid, s2_valid and all pipeline data registers.
  - Drives sum=0, cout=0, ovf=0, zero=0 and out_valid=0.
  - in_ready is 1 in the first cycle after reset.
  - Any in-flight beats are discarded, and no partial result ever appears.
- Operand conditioning: beff = b XOR {32{sub}}, cin = sub.
- Stage 1 (on input handshake in_valid & in_ready) registers:
  - sum[15:0], computed by the low CLA slice with cin;
  - c16, the slice carry-out, computed from the slice block G/P as G | (P & cin);
  - a[31:16] and beff[31:16].
  - Sets s1_valid.
- Stage 2 (when the stage advances) computes:
  - sum[31:16] from the high slice with c16;
  - cout = carry out of bit 31;
  - ovf = (a31 == beff31) & (sum31 != a31), using the conditioned operand;
  - zero = ~|sum.
  - It registers all of the above and sets s2_valid = s1_valid.
- Handshake and flow control:
  - adv2 = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | adv2. This path is combinational from registers and out_ready, with no dependence on in_valid.
  - out_valid = s2_valid.
  - If s2_valid & out_ready & ~s1_valid, s2_valid clears.
  - Stage 1 loads on in_valid & in_ready. If the stage is emptying with no new beat, s1_valid clears.
- Latency: an accepted beat appears on out_valid at the 2nd rising edge after acceptance, provided there is no backpressure.
- Throughput: 1 beat/cycle while out_ready is held at 1.
- Backpressure: while out_valid & ~out_ready, sum/cout/ovf/zero hold stable.
  - Stage 1 holds its beat.
  - in_ready drops once both stages are full.
  - No beat is lost or duplicated, and results leave in acceptance order.
- Simultaneous events: in the same cycle as s2 drains, s1 may advance into s2 and a new beat may load into s1 (full-rate flow-through).
- Reset mid-operation: reset has priority over every handshake in that cycle.
- Arithmetic: all results are modulo 2^32. The sub bit travels with its beat, so add and sub may interleave beat by beat.

Test Plan:
- Inter-slice carry: a=0x0000FFFF, b=0x00000001, sub=0 -> sum=0x00010000, cout=0, ovf=0, zero=0, out_valid exactly 2 cycles after accept.
- Signed overflow add: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0. Also a=0xFFFFFFFF, b=1 -> sum=0, cout=1, zero=1, ovf=0.
- Subtraction and borrow:
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
  - a=b=0x12345678, sub=1 -> sum=0, zero=1, cout=1.
- Streaming: 8 back-to-back beats with alternating sub and out_ready=1 -> 8 results on consecutive cycles, in order, in_ready never 0.
- Backpressure: hold out_ready=0 for 5 cycles while feeding beats -> in_ready=0 after 2 accepted beats, outputs stable, all beats later delivered in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 for 1 cycle with both stages full -> next cycle out_valid=0, sum=0, cout=ovf=zero=0, in_ready=1, and none of the discarded beats ever emerge.
